reorder_buffer: RTL and testbench

- Circular reorder buffer sitting directly upstream of the retire/commit stage.
- Dispatch allocates one entry per cycle in program order; writeback marks entries complete by tag.
- The oldest entry is presented to retire/commit. That stage handshakes it out and uses the arch/phys/old-phys fields to update the retirement RAT and free the old physical register.
- Provides a single-cycle full flush for mispredict/exception recovery.

---
 rtl/reorder_buffer_if.sv | 52 +++++
 rtl/reorder_buffer.sv | 131 +++++++++++++
 tb/tb_reorder_buffer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / retire-side signal bundle of the reorder buffer.
// master = pipeline stages driving it, slave = the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int ROB_DEPTH     = 32,
    parameter int ARCH_REG_BITS = 6
);
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int LOG_ROB  = $clog2(ROB_DEPTH);

    logic                     alloc_valid;
    logic                     alloc_has_dst;
    logic [ARCH_REG_BITS-1:0] alloc_arch_dst;
    logic [LOG_PHYS-1:0]      alloc_phys_dst;
    logic [LOG_PHYS-1:0]      alloc_old_phys;
    logic                     alloc_is_store;
    logic                     alloc_ready;
    logic [LOG_ROB-1:0]       alloc_tag;

    logic                     complete_valid;
    logic [LOG_ROB-1:0]       complete_tag;

    logic                     retire_valid;
    logic                     retire_has_dst;
    logic [ARCH_REG_BITS-1:0] retire_arch_dst;
    logic [LOG_PHYS-1:0]      retire_phys_dst;
    logic [LOG_PHYS-1:0]      retire_old_phys;
    logic                     retire_is_store;
    logic                     retire_ack;

    logic                     flush;
    logic [LOG_ROB:0]         count;
    logic                     empty;

    modport master (
        output alloc_valid, alloc_has_dst, alloc_arch_dst, alloc_phys_dst,
               alloc_old_phys, alloc_is_store, complete_valid, complete_tag,
               retire_ack, flush,
        input  alloc_ready, alloc_tag, retire_valid, retire_has_dst,
               retire_arch_dst, retire_phys_dst, retire_old_phys,
               retire_is_store, count, empty
    );

    modport slave (
        input  alloc_valid, alloc_has_dst, alloc_arch_dst, alloc_phys_dst,
               alloc_old_phys, alloc_is_store, complete_valid, complete_tag,
               retire_ack, flush,
        output alloc_ready, alloc_tag, retire_valid, retire_has_dst,
               retire_arch_dst, retire_phys_dst, retire_old_phys,
               retire_is_store, count, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete by tag, in-order retire of the head.
// All updates land on the next edge; alloc stalls via alloc_ready when full, retire waits for retire_ack.
module reorder_buffer #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int ROB_DEPTH     = 32,
    parameter int ARCH_REG_BITS = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    reorder_buffer_if.slave   rob
);
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int LOG_ROB  = $clog2(ROB_DEPTH);
    localparam logic [LOG_ROB:0] PTR_ONE  = (LOG_ROB+1)'(1);
    localparam logic [LOG_ROB:0] DEPTH_W  = (LOG_ROB+1)'(ROB_DEPTH);

    typedef struct packed {
        logic                     has_dst;
        logic [ARCH_REG_BITS-1:0] arch_dst;
        logic [LOG_PHYS-1:0]      phys_dst;
        logic [LOG_PHYS-1:0]      old_phys;
        logic                     is_store;
    } entry_t;

    logic [LOG_ROB:0]     head_q, head_d;
    logic [LOG_ROB:0]     tail_q, tail_d;
    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    entry_t               pay_q [ROB_DEPTH];
    entry_t               pay_d;
    entry_t               head_ent;

    logic [LOG_ROB-1:0]   head_idx;
    logic [LOG_ROB-1:0]   tail_idx;
    logic                 empty_w;
    logic                 full_w;
    logic                 head_live;
    logic                 retire_vld;
    logic                 alloc_fire;
    logic                 retire_fire;
    logic                 complete_hit;

    assign head_idx = head_q[LOG_ROB-1:0];
    assign tail_idx = tail_q[LOG_ROB-1:0];
    assign empty_w  = (head_q == tail_q);
    assign full_w   = (head_idx == tail_idx) && (head_q[LOG_ROB] != tail_q[LOG_ROB]);

    assign head_live  = !empty_w && valid_q[head_idx];
    assign retire_vld = head_live && done_q[head_idx];

    // Flush squashes every same-cycle event, including an ack of a visible head.
    assign alloc_fire   = rob.alloc_valid && !full_w && !rob.flush;
    assign retire_fire  = retire_vld && rob.retire_ack && !rob.flush;
    assign complete_hit = rob.complete_valid && valid_q[rob.complete_tag] && !rob.flush;

    assign pay_d = '{
        has_dst:  rob.alloc_has_dst,
        arch_dst: rob.alloc_arch_dst,
        phys_dst: rob.alloc_phys_dst,
        old_phys: rob.alloc_old_phys,
        is_store: rob.alloc_is_store
    };

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (complete_hit) begin
            done_d[rob.complete_tag] = 1'b1;
        end
        if (retire_fire) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + PTR_ONE;
        end
        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + PTR_ONE;
        end
        if (rob.flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid head entry.
    always_ff @(posedge CLK) begin
        if (!RESET && alloc_fire) begin
            pay_q[tail_idx] <= pay_d;
        end
    end

    assign head_ent = head_live ? pay_q[head_idx] : '0;

    assign rob.alloc_ready     = !full_w;
    assign rob.alloc_tag       = tail_idx;
    assign rob.retire_valid    = retire_vld;
    assign rob.retire_has_dst  = head_ent.has_dst;
    assign rob.retire_arch_dst = head_ent.arch_dst;
    assign rob.retire_phys_dst = head_ent.phys_dst;
    assign rob.retire_old_phys = head_ent.old_phys;
    assign rob.retire_is_store = head_ent.is_store;
    assign rob.count           = tail_q - head_q;
    assign rob.empty           = empty_w;

    a_count_bound: assert property (@(posedge CLK) disable iff (RESET)
        (tail_q - head_q) <= DEPTH_W);
    a_valid_matches_count: assert property (@(posedge CLK) disable iff (RESET)
        (LOG_ROB+1)'($countones(valid_q)) == (tail_q - head_q));
    a_done_implies_valid: assert property (@(posedge CLK) disable iff (RESET)
        (done_q & ~valid_q) == '0);
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus hand-written full/wrap/flush sequences.
module tb_reorder_buffer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    reorder_buffer_if #(.NUM_PHYS_REGS(64), .ROB_DEPTH(32), .ARCH_REG_BITS(6)) rob_if ();

    reorder_buffer #(.NUM_PHYS_REGS(64), .ROB_DEPTH(32), .ARCH_REG_BITS(6)) dut (
        .CLK   (clk),
        .RESET (rst),
        .rob   (rob_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    typedef struct packed {
        logic       rst;
        logic       av;
        logic       hd;
        logic [5:0] arch;
        logic [5:0] phys;
        logic [5:0] old;
        logic       st;
        logic       cv;
        logic [4:0] ct;
        logic       ack;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic       ready;
        logic [4:0] tag;
        logic       rv;
        logic [5:0] phys;
        logic [5:0] arch;
        logic [5:0] old;
        logic       hd;
        logic       st;
        logic [5:0] count;
        logic       empty;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs [$];

    function automatic in_t mk_in(logic r, logic av, logic hd, int arch, int phys, int old,
                                  logic st, logic cv, int ct, logic ack, logic fl);
        in_t v;
        v.rst = r; v.av = av; v.hd = hd;
        v.arch = 6'(arch); v.phys = 6'(phys); v.old = 6'(old);
        v.st = st; v.cv = cv; v.ct = 5'(ct); v.ack = ack; v.fl = fl;
        return v;
    endfunction

    function automatic exp_t mk_ex(logic ready, int tag, logic rv, int phys, int arch, int old,
                                   logic hd, logic st, int cnt, logic emp);
        exp_t v;
        v.ready = ready; v.tag = 5'(tag); v.rv = rv;
        v.phys = 6'(phys); v.arch = 6'(arch); v.old = 6'(old);
        v.hd = hd; v.st = st; v.count = 6'(cnt); v.empty = emp;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob_if.alloc_valid    = 1'b0;
        rob_if.alloc_has_dst  = 1'b0;
        rob_if.alloc_arch_dst = '0;
        rob_if.alloc_phys_dst = '0;
        rob_if.alloc_old_phys = '0;
        rob_if.alloc_is_store = 1'b0;
        rob_if.complete_valid = 1'b0;
        rob_if.complete_tag   = '0;
        rob_if.retire_ack     = 1'b0;
        rob_if.flush          = 1'b0;
    endtask

    task automatic drive(input in_t v);
        rst                   = v.rst;
        rob_if.alloc_valid    = v.av;
        rob_if.alloc_has_dst  = v.hd;
        rob_if.alloc_arch_dst = v.arch;
        rob_if.alloc_phys_dst = v.phys;
        rob_if.alloc_old_phys = v.old;
        rob_if.alloc_is_store = v.st;
        rob_if.complete_valid = v.cv;
        rob_if.complete_tag   = v.ct;
        rob_if.retire_ack     = v.ack;
        rob_if.flush          = v.fl;
    endtask

    task automatic alloc_drive(input int arch, input int phys, input int old);
        rob_if.alloc_valid    = 1'b1;
        rob_if.alloc_has_dst  = 1'b1;
        rob_if.alloc_arch_dst = 6'(arch);
        rob_if.alloc_phys_dst = 6'(phys);
        rob_if.alloc_old_phys = 6'(old);
        rob_if.alloc_is_store = 1'b0;
    endtask

    task automatic do_reset(input string tagname);
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk({tagname, "_count"}, int'(rob_if.count), 0);
        chk({tagname, "_empty"}, int'(rob_if.empty), 1);
        chk({tagname, "_ready"}, int'(rob_if.alloc_ready), 1);
        chk({tagname, "_tag"}, int'(rob_if.alloc_tag), 0);
        chk({tagname, "_rv"}, int'(rob_if.retire_valid), 0);
    endtask

    int rcount;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();

        // Reset, in-order retire of out-of-order completions, stale completion, alloc+retire at count 5.
        vecs.push_back({mk_in(1,0,0,0,0,0,0,0,0,0,0),  mk_ex(1,0,0,0,0,0,0,0,0,1)});
        vecs.push_back({mk_in(1,0,0,0,0,0,0,0,0,0,0),  mk_ex(1,0,0,0,0,0,0,0,0,1)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,0,0,0,0),  mk_ex(1,0,0,0,0,0,0,0,0,1)});
        vecs.push_back({mk_in(0,1,1,2,40,2,0,0,0,0,0), mk_ex(1,1,0,40,2,2,1,0,1,0)});
        vecs.push_back({mk_in(0,1,1,5,41,5,1,0,0,0,0), mk_ex(1,2,0,40,2,2,1,0,2,0)});
        vecs.push_back({mk_in(0,1,1,7,42,7,0,0,0,0,0), mk_ex(1,3,0,40,2,2,1,0,3,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,1,2,1,0),  mk_ex(1,3,0,40,2,2,1,0,3,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,1,1,1,0),  mk_ex(1,3,0,40,2,2,1,0,3,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,1,0,1,0),  mk_ex(1,3,1,40,2,2,1,0,3,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,0,0,1,0),  mk_ex(1,3,1,41,5,5,1,1,2,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,0,0,1,0),  mk_ex(1,3,1,42,7,7,1,0,1,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,0,0,1,0),  mk_ex(1,3,0,0,0,0,0,0,0,1)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,1,9,0,0),  mk_ex(1,3,0,0,0,0,0,0,0,1)});
        vecs.push_back({mk_in(0,1,1,1,10,20,0,0,0,0,0), mk_ex(1,4,0,10,1,20,1,0,1,0)});
        vecs.push_back({mk_in(0,1,0,3,11,21,0,0,0,0,0), mk_ex(1,5,0,10,1,20,1,0,2,0)});
        vecs.push_back({mk_in(0,1,1,4,12,22,0,0,0,0,0), mk_ex(1,6,0,10,1,20,1,0,3,0)});
        vecs.push_back({mk_in(0,1,1,6,13,23,0,0,0,0,0), mk_ex(1,7,0,10,1,20,1,0,4,0)});
        vecs.push_back({mk_in(0,1,1,8,14,24,0,0,0,0,0), mk_ex(1,8,0,10,1,20,1,0,5,0)});
        vecs.push_back({mk_in(0,0,0,0,0,0,0,1,3,0,0),  mk_ex(1,8,1,10,1,20,1,0,5,0)});
        vecs.push_back({mk_in(0,1,1,9,15,25,0,0,0,1,0), mk_ex(1,9,0,11,3,21,0,0,5,0)});

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            tick();
            chk($sformatf("v%0d_ready", k), int'(rob_if.alloc_ready), int'(vecs[k].e.ready));
            chk($sformatf("v%0d_tag", k), int'(rob_if.alloc_tag), int'(vecs[k].e.tag));
            chk($sformatf("v%0d_rv", k), int'(rob_if.retire_valid), int'(vecs[k].e.rv));
            chk($sformatf("v%0d_phys", k), int'(rob_if.retire_phys_dst), int'(vecs[k].e.phys));
            chk($sformatf("v%0d_arch", k), int'(rob_if.retire_arch_dst), int'(vecs[k].e.arch));
            chk($sformatf("v%0d_old", k), int'(rob_if.retire_old_phys), int'(vecs[k].e.old));
            chk($sformatf("v%0d_hasdst", k), int'(rob_if.retire_has_dst), int'(vecs[k].e.hd));
            chk($sformatf("v%0d_store", k), int'(rob_if.retire_is_store), int'(vecs[k].e.st));
            chk($sformatf("v%0d_count", k), int'(rob_if.count), int'(vecs[k].e.count));
            chk($sformatf("v%0d_empty", k), int'(rob_if.empty), int'(vecs[k].e.empty));
        end

        // Full boundary.
        do_reset("rst_full");
        for (int i = 0; i < 32; i++) begin
            chk("full_alloc_tag", int'(rob_if.alloc_tag), i);
            alloc_drive(i, i, i);
            tick();
        end
        chk("full_count", int'(rob_if.count), 32);
        chk("full_ready", int'(rob_if.alloc_ready), 0);
        chk("full_tag", int'(rob_if.alloc_tag), 0);
        alloc_drive(1, 63, 63);
        tick();
        chk("full_ignored_count", int'(rob_if.count), 32);
        chk("full_ignored_tag", int'(rob_if.alloc_tag), 0);
        chk("full_head_intact", int'(rob_if.retire_phys_dst), 0);
        rob_if.complete_valid = 1'b1;
        rob_if.complete_tag   = 5'd0;
        tick();
        rob_if.complete_valid = 1'b0;
        chk("full_head_rv", int'(rob_if.retire_valid), 1);
        chk("full_head_count", int'(rob_if.count), 32);
        rob_if.retire_ack = 1'b1;
        tick();
        rob_if.retire_ack = 1'b0;
        chk("full_retire_count", int'(rob_if.count), 31);
        chk("full_retire_ready", int'(rob_if.alloc_ready), 1);
        chk("full_retire_nexthead", int'(rob_if.retire_phys_dst), 1);
        chk("full_retire_rv", int'(rob_if.retire_valid), 0);
        tick();
        chk("full_refill_count", int'(rob_if.count), 32);
        chk("full_refill_ready", int'(rob_if.alloc_ready), 0);
        idle_inputs();

        // Reset with a full buffer in flight.
        do_reset("rst_midop");

        // Wrap-around streaming: alloc k, complete k-1, ack held.
        rcount = 0;
        for (int k = 0; k < 44; k++) begin
            if (k < 40) begin
                chk("wrap_alloc_tag", int'(rob_if.alloc_tag), k % 32);
                alloc_drive(k % 35, (k * 3 + 1) % 64, k % 64);
            end else begin
                rob_if.alloc_valid = 1'b0;
            end
            rob_if.complete_valid = (k >= 1 && k <= 40);
            rob_if.complete_tag   = 5'((k + 31) % 32);
            rob_if.retire_ack     = 1'b1;
            if (rob_if.retire_valid) begin
                chk("wrap_retire_phys", int'(rob_if.retire_phys_dst), (rcount * 3 + 1) % 64);
                rcount++;
            end
            tick();
            chk("wrap_count_le2", int'(rob_if.count <= 6'd2), 1);
        end
        chk("wrap_retired", rcount, 40);
        chk("wrap_empty", int'(rob_if.empty), 1);
        idle_inputs();

        // Flush mid-stream with simultaneous alloc, completion and ack.
        do_reset("rst_flush");
        for (int i = 0; i < 10; i++) begin
            alloc_drive(i, 20 + i, i);
            tick();
        end
        rob_if.alloc_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rob_if.complete_valid = 1'b1;
            rob_if.complete_tag   = 5'(t);
            tick();
        end
        rob_if.complete_valid = 1'b0;
        chk("flush_pre_rv", int'(rob_if.retire_valid), 1);
        chk("flush_pre_count", int'(rob_if.count), 10);
        alloc_drive(5, 50, 5);
        rob_if.retire_ack     = 1'b1;
        rob_if.complete_valid = 1'b1;
        rob_if.complete_tag   = 5'd4;
        rob_if.flush          = 1'b1;
        tick();
        idle_inputs();
        chk("flush_count", int'(rob_if.count), 0);
        chk("flush_empty", int'(rob_if.empty), 1);
        chk("flush_rv", int'(rob_if.retire_valid), 0);
        chk("flush_tag", int'(rob_if.alloc_tag), 0);
        chk("flush_phys", int'(rob_if.retire_phys_dst), 0);
        tick();
        chk("flush_no_alloc", int'(rob_if.count), 0);
        alloc_drive(3, 33, 9);
        tick();
        idle_inputs();
        chk("postflush_count", int'(rob_if.count), 1);
        chk("postflush_rv", int'(rob_if.retire_valid), 0);
        chk("postflush_phys", int'(rob_if.retire_phys_dst), 33);
        chk("postflush_tag", int'(rob_if.alloc_tag), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
